// File: rtl/seq_ctrl_timing.sv
// Sequencer driven by the one-hot T0..T15 timing lines: fetch, decode, execute.
// Define SEQ_TIMING_CHECK_EN to enable the timing-line check and sticky ERR flag.
module seq_ctrl_timing #(
    parameter int unsigned     OP_W    = 5,
    parameter int unsigned     NSTEP   = 16,
    parameter logic [OP_W-1:0] HALT_OP = '1
) (
    input  logic             CLK,
    input  logic             CLR,
    input  logic [NSTEP-1:0] T,
    input  logic [OP_W-1:0]  OPCODE,
    input  logic             START,
    input  logic             STOP_REQ,
    output logic             SC_CLR,
    output logic             LD_AR,
    output logic             INC_PC,
    output logic             LD_IR,
    output logic             DECODE,
    output logic             EXEC,
    output logic [1:0]       EXEC_STEP,
    output logic             BUSY,
    output logic             HALTED,
    output logic             ERR
);

    localparam int unsigned STEP_W = 4;
    localparam int unsigned LEN_W  = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        DEC   = 3'd2,
        EXE   = 3'd3,
        HALT  = 3'd4
    } state_t;

    state_t            state, nxt_state;
    logic [STEP_W-1:0] step, nxt_step;
    logic [LEN_W-1:0]  exec_len, nxt_len;
    logic              stop_pend, nxt_stop;
    logic              busy_now, last_step, nxt_last, mismatch;

    assign busy_now  = (state == FETCH) || (state == DEC) || (state == EXE);
    assign last_step = (state == EXE) && (step == STEP_W'(exec_len) + STEP_W'(3));

`ifdef SEQ_TIMING_CHECK_EN
    logic first_fetch;

    // First FETCH cycle after IDLE is exempt: the counter is just leaving its clear.
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            first_fetch <= 1'b0;
            ERR         <= 1'b0;
        end else begin
            first_fetch <= (state == IDLE) && START;
            ERR         <= ERR | mismatch;
        end
    end

    assign mismatch = busy_now && !first_fetch && (T != (NSTEP'(1) << step));
`else
    logic unused_t;

    assign unused_t = ^T;
    assign mismatch = 1'b0;
    assign ERR      = 1'b0;
`endif

    // Next-state and shadow step logic
    always_comb begin
        nxt_state = state;
        nxt_step  = step;
        nxt_len   = exec_len;
        nxt_stop  = stop_pend;
        if (busy_now && STOP_REQ) begin
            nxt_stop = 1'b1;
        end
        unique case (state)
            IDLE: begin
                nxt_step = '0;
                if (START) begin
                    nxt_state = FETCH;
                end
            end
            FETCH: begin
                nxt_step = step + STEP_W'(1);
                if (step == STEP_W'(2)) begin
                    nxt_state = DEC;
                end
            end
            DEC: begin
                unique case (OPCODE[OP_W-1 -: 2])
                    2'b00:   nxt_len = LEN_W'(1);
                    2'b01:   nxt_len = LEN_W'(3);
                    2'b10:   nxt_len = LEN_W'(2);
                    default: nxt_len = LEN_W'(4);
                endcase
                nxt_state = EXE;
                nxt_step  = step + STEP_W'(1);
            end
            EXE: begin
                if (last_step) begin
                    nxt_step = '0;
                    if (OPCODE == HALT_OP) begin
                        nxt_state = HALT;
                    end else if (stop_pend || STOP_REQ) begin
                        nxt_state = IDLE;
                        nxt_stop  = 1'b0;
                    end else begin
                        nxt_state = FETCH;
                    end
                end else begin
                    nxt_step = step + STEP_W'(1);
                end
            end
            HALT: begin
                nxt_step = '0;
            end
            default: begin
                nxt_state = IDLE;
                nxt_step  = '0;
            end
        endcase
        if (mismatch) begin
            nxt_state = HALT;
            nxt_step  = '0;
        end
    end

    assign nxt_last = (nxt_state == EXE) && (nxt_step == STEP_W'(nxt_len) + STEP_W'(3));

    // State registers; outputs are registered from the next state so they track state/step exactly
    always_ff @(posedge CLK or posedge CLR) begin
        if (CLR) begin
            state     <= IDLE;
            step      <= '0;
            exec_len  <= LEN_W'(1);
            stop_pend <= 1'b0;
            SC_CLR    <= 1'b1;
            LD_AR     <= 1'b0;
            INC_PC    <= 1'b0;
            LD_IR     <= 1'b0;
            DECODE    <= 1'b0;
            EXEC      <= 1'b0;
            EXEC_STEP <= 2'b0;
            BUSY      <= 1'b0;
            HALTED    <= 1'b0;
        end else begin
            state     <= nxt_state;
            step      <= nxt_step;
            exec_len  <= nxt_len;
            stop_pend <= nxt_stop;
            SC_CLR    <= (nxt_state == IDLE) || (nxt_state == HALT) || nxt_last;
            LD_AR     <= (nxt_state == FETCH) && (nxt_step == STEP_W'(0));
            INC_PC    <= (nxt_state == FETCH) && (nxt_step == STEP_W'(1));
            LD_IR     <= (nxt_state == FETCH) && (nxt_step == STEP_W'(2));
            DECODE    <= (nxt_state == DEC);
            EXEC      <= (nxt_state == EXE);
            EXEC_STEP <= (nxt_state == EXE) ? 2'(nxt_step - STEP_W'(4)) : 2'b0;
            BUSY      <= (nxt_state == FETCH) || (nxt_state == DEC) || (nxt_state == EXE);
            HALTED    <= (nxt_state == HALT);
        end
    end

endmodule

// File: tb/tb_seq_ctrl_timing.sv
// Self-checking bench for seq_ctrl_timing with a sequence-counter model and an
// instruction-level expected-output model.
module tb_seq_ctrl_timing;

    logic        CLK = 1'b0;
    logic        CLR = 1'b1;
    logic [15:0] T;
    logic [4:0]  OPCODE = 5'b0;
    logic        START = 1'b0;
    logic        STOP_REQ = 1'b0;
    logic        SC_CLR, LD_AR, INC_PC, LD_IR, DECODE, EXEC, BUSY, HALTED, ERR;
    logic [1:0]  EXEC_STEP;

    int passed = 0;
    int total  = 0;

    logic [3:0]  cnt = 4'd0;
    logic        force_en = 1'b0;
    logic [15:0] force_val = 16'b0;
    logic [9:0]  obs;

    localparam logic [9:0] IDLE_V = 10'b10_0000_0000;
    localparam logic [9:0] HALT_V = 10'b10_0000_0001;

    seq_ctrl_timing dut (
        .CLK(CLK), .CLR(CLR), .T(T), .OPCODE(OPCODE), .START(START), .STOP_REQ(STOP_REQ),
        .SC_CLR(SC_CLR), .LD_AR(LD_AR), .INC_PC(INC_PC), .LD_IR(LD_IR), .DECODE(DECODE),
        .EXEC(EXEC), .EXEC_STEP(EXEC_STEP), .BUSY(BUSY), .HALTED(HALTED), .ERR(ERR)
    );

    always #5 CLK = ~CLK;

    // External sequence counter: clears on SC_CLR, otherwise counts up
    always @(posedge CLK) begin
        if (SC_CLR) cnt <= 4'd0;
        else        cnt <= cnt + 4'd1;
    end

    assign T   = force_en ? force_val : (16'd1 << cnt);
    assign obs = {SC_CLR, LD_AR, INC_PC, LD_IR, DECODE, EXEC, EXEC_STEP, BUSY, HALTED};

    function automatic int len_of(input logic [4:0] op);
        case (op[4:3])
            2'b00:   return 1;
            2'b01:   return 3;
            2'b10:   return 2;
            default: return 4;
        endcase
    endfunction

    // Expected outputs for cycle k of an instruction with len execute cycles
    function automatic logic [9:0] exp_vec(input int k, input int len);
        logic [1:0] es;
        es = (k >= 4) ? 2'(k - 4) : 2'd0;
        return {(k == 3 + len), (k == 0), (k == 1), (k == 2), (k == 3), (k >= 4), es, 1'b1, 1'b0};
    endfunction

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic apply_reset();
        CLR = 1'b1; START = 1'b0; STOP_REQ = 1'b0; force_en = 1'b0;
        tick();
        tick();
        CLR = 1'b0;
    endtask

    task automatic begin_instr(input logic [4:0] op);
        OPCODE = op;
        START = 1'b1;
        tick();
        START = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        total++;
        if (obs !== IDLE_V || ERR !== 1'b0) $display("FAIL reset: obs=%b err=%b want %b err=0", obs, ERR, IDLE_V);
        else passed++;
        tick();
        total++;
        if (obs !== IDLE_V || cnt !== 4'd0) $display("FAIL idle_hold: obs=%b cnt=%0d want %b cnt=0", obs, cnt, IDLE_V);
        else passed++;
    endtask

    task automatic test_fetch_exec();
        apply_reset();
        begin_instr(5'b00010);
        for (int k = 0; k <= 4; k++) begin
            total++;
            if (obs !== exp_vec(k, 1) || cnt !== 4'(k))
                $display("FAIL fetch_exec k=%0d: obs=%b cnt=%0d want %b cnt=%0d", k, obs, cnt, exp_vec(k, 1), k);
            else passed++;
            tick();
        end
        total++;
        if (obs !== exp_vec(0, 1) || cnt !== 4'd0)
            $display("FAIL fetch_restart: obs=%b cnt=%0d want %b cnt=0", obs, cnt, exp_vec(0, 1));
        else passed++;
    endtask

    task automatic test_long_exec();
        apply_reset();
        begin_instr(5'b11000);
        for (int k = 0; k <= 7; k++) begin
            total++;
            if (obs !== exp_vec(k, 4)) $display("FAIL long_exec k=%0d: obs=%b want %b", k, obs, exp_vec(k, 4));
            else passed++;
            tick();
        end
        total++;
        if (obs !== exp_vec(0, 4) || cnt !== 4'd0)
            $display("FAIL long_restart: obs=%b cnt=%0d want %b cnt=0", obs, cnt, exp_vec(0, 4));
        else passed++;
    endtask

    task automatic test_stop();
        apply_reset();
        begin_instr(5'b01000);
        for (int k = 0; k <= 6; k++) begin
            total++;
            if (obs !== exp_vec(k, 3)) $display("FAIL stop_instr k=%0d: obs=%b want %b", k, obs, exp_vec(k, 3));
            else passed++;
            STOP_REQ = (k == 1);
            tick();
            STOP_REQ = 1'b0;
        end
        for (int i = 0; i < 5; i++) begin
            total++;
            if (obs !== IDLE_V) $display("FAIL stop_idle i=%0d: obs=%b want %b", i, obs, IDLE_V);
            else passed++;
            tick();
        end
    endtask

    task automatic test_halt();
        apply_reset();
        begin_instr(5'b11111);
        for (int k = 0; k <= 7; k++) begin
            total++;
            if (obs !== exp_vec(k, 4)) $display("FAIL halt_instr k=%0d: obs=%b want %b", k, obs, exp_vec(k, 4));
            else passed++;
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            START = 1'b1;
            tick();
            START = 1'b0;
            total++;
            if (obs !== HALT_V) $display("FAIL halt_hold i=%0d: obs=%b want %b", i, obs, HALT_V);
            else passed++;
        end
        CLR = 1'b1;
        #1;
        total++;
        if (obs !== IDLE_V) $display("FAIL halt_clr: obs=%b want %b", obs, IDLE_V);
        else passed++;
        tick();
        CLR = 1'b0;
    endtask

    task automatic test_timing_err();
        apply_reset();
        begin_instr(5'b01000);
        for (int k = 0; k < 4; k++) tick();
        force_en  = 1'b1;
        force_val = 16'd1 << 5;
        tick();
        force_en  = 1'b0;
`ifdef SEQ_TIMING_CHECK_EN
        total++;
        if (ERR !== 1'b1 || obs !== HALT_V) $display("FAIL timing_err: err=%b obs=%b want err=1 %b", ERR, obs, HALT_V);
        else passed++;
        for (int i = 0; i < 10; i++) begin
            START = 1'b1;
            tick();
            START = 1'b0;
            tick();
            total++;
            if (ERR !== 1'b1 || obs !== HALT_V) $display("FAIL err_sticky i=%0d: err=%b obs=%b", i, ERR, obs);
            else passed++;
        end
        apply_reset();
        total++;
        if (ERR !== 1'b0 || obs !== IDLE_V) $display("FAIL err_clr: err=%b obs=%b want err=0 %b", ERR, obs, IDLE_V);
        else passed++;
`else
        for (int k = 5; k <= 6; k++) begin
            total++;
            if (ERR !== 1'b0 || obs !== exp_vec(k, 3)) $display("FAIL no_check k=%0d: err=%b obs=%b want %b", k, ERR, obs, exp_vec(k, 3));
            else passed++;
            tick();
        end
        total++;
        if (ERR !== 1'b0 || obs !== exp_vec(0, 3)) $display("FAIL no_check_restart: err=%b obs=%b", ERR, obs);
        else passed++;
`endif
    endtask

    task automatic test_reset_mid();
        apply_reset();
        begin_instr(5'b11000);
        for (int k = 0; k < 5; k++) tick();
        total++;
        if (obs !== exp_vec(5, 4)) $display("FAIL mid_pre: obs=%b want %b", obs, exp_vec(5, 4));
        else passed++;
        CLR = 1'b1;
        #1;
        total++;
        if (obs !== IDLE_V || ERR !== 1'b0) $display("FAIL mid_reset: obs=%b err=%b want %b", obs, ERR, IDLE_V);
        else passed++;
        tick();
        CLR = 1'b0;
        tick();
        total++;
        if (obs !== IDLE_V) $display("FAIL mid_after: obs=%b want %b", obs, IDLE_V);
        else passed++;
    endtask

    task automatic test_random();
        logic [4:0] op;
        int         len;
        bit         stop;
        apply_reset();
        begin_instr(5'b00000);
        for (int n = 0; n < 40; n++) begin
            op = 5'($urandom);
            if (op == 5'b11111) op = 5'b00001;
            OPCODE = op;
            len = len_of(op);
            stop = 1'b0;
            for (int k = 0; k <= 3 + len; k++) begin
                total++;
                if (obs !== exp_vec(k, len) || ERR !== 1'b0)
                    $display("FAIL random n=%0d k=%0d op=%b: obs=%b err=%b want %b", n, k, op, obs, ERR, exp_vec(k, len));
                else passed++;
                STOP_REQ = ($urandom_range(0, 9) == 0);
                START    = 1'($urandom);
                if (STOP_REQ) stop = 1'b1;
                tick();
            end
            STOP_REQ = 1'b0;
            START    = 1'b0;
            if (stop) begin
                for (int i = 0; i <= $urandom_range(0, 3); i++) begin
                    total++;
                    if (obs !== IDLE_V) $display("FAIL random_idle n=%0d: obs=%b want %b", n, obs, IDLE_V);
                    else passed++;
                    tick();
                end
                START = 1'b1;
                tick();
                START = 1'b0;
            end
        end
    endtask

    initial begin
        test_reset();
        test_fetch_exec();
        test_long_exec();
        test_stop();
        test_halt();
        test_timing_err();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, passed=%0d total=%0d", passed, total);
        $fatal(1);
    end

endmodule

// File: doc/seq_ctrl_timing.md
Name: seq_ctrl_timing

Overview:
- Consumer end of the sequence-counter timing interface in the 19-bit CPU.
- Takes the one-hot T0..T15 timing lines from the sequence counter and steps through fetch, decode and execute. Execute length depends on the opcode class.
- Drives the counter's clear line (SC_CLR) so that the counter returns to T0 at the end of every instruction.
- Keeps a shadow step count, checks the incoming timing lines against it, and flags any mismatch.

Parameters:
- OP_W, 5, opcode width (instruction bits 18:14).
- NSTEP, 16, number of timing lines; the shadow step count is 4 bits.
- HALT_OP, 5'b11111, opcode that halts the sequencer.

Ports:
- CLK  input  1  system clock, rising edge.
- CLR  input  1  reset, asynchronous, active-high.
- T  input  16  timing lines from the sequence counter; T[i] = Ti, one-hot.
- OPCODE  input  OP_W  opcode from the IR; valid from T3 onward.
- START  input  1  single-cycle pulse that begins execution from IDLE.
- STOP_REQ  input  1  request to stop at the next instruction boundary.
- SC_CLR  output  1  clear to the sequence counter.
- LD_AR  output  1  fetch step 0: load AR from PC.
- INC_PC  output  1  fetch step 1: increment PC.
- LD_IR  output  1  fetch step 2: load IR from memory.
- DECODE  output  1  high during step 3.
- EXEC  output  1  high during execute steps.
- EXEC_STEP  output  2  execute step index, 0..3.
- BUSY  output  1  high in FETCH, DEC and EXE.
- HALTED  output  1  high in HALT.
- ERR  output  1  sticky timing-mismatch flag.

Behaviour:
- States: IDLE, FETCH, DEC, EXE, HALT. Registers: state, 4-bit step, 3-bit exec_len, ERR, stop_pend.
- Reset (async, CLR=1): state=IDLE, step=0, ERR=0, stop_pend=0. SC_CLR=1, all other outputs 0.
- Every output is decoded from registered state and step only. No output has a combinational path from an input.
- IDLE:
  - SC_CLR=1, which holds the counter at T0.
  - START=1 moves to FETCH with step=0 at the next edge. SC_CLR goes low in that same cycle.
- FETCH:
  - step 0 → LD_AR=1; step 1 → INC_PC=1; step 2 → LD_IR=1.
  - step increments each cycle. After step 2 → DEC with step=3.
- DEC:
  - DECODE=1.
  - Latch exec_len from OPCODE[4:3]: 00→1, 01→3, 10→2, 11→4.
  - Next state is EXE with step=4.
- EXE:
  - EXEC=1 and EXEC_STEP=step-4. step increments each cycle.
  - Last step is step == 3+exec_len.
  - On the last step SC_CLR=1, so the counter returns to T0 at the next edge.
  - After the last step the next state is:
    - HALT if OPCODE==HALT_OP;
    - else IDLE if stop_pend or STOP_REQ is set (stop_pend then clears);
    - else FETCH with step=0.
- STOP_REQ:
  - Sampled every BUSY cycle and sets stop_pend.
  - STOP_REQ in IDLE or HALT has no effect.
- START while BUSY or HALT is ignored.
- HALT:
  - SC_CLR=1 and HALTED=1.
  - Only CLR exits this state.
- Timing check:
  - Applies when BUSY=1 and the cycle is not the first FETCH cycle after IDLE.
  - Mismatch condition: T != (16'b1 << step).
  - On mismatch: ERR=1 at the next edge, state goes to HALT. ERR stays set until CLR.
- Wrap-around: step never exceeds 7. Steps 8..15 are unreachable. Observing T8..T15 while BUSY is a mismatch.
- Reset mid-instruction returns to IDLE immediately, and SC_CLR goes high asynchronously with reset.

Optional Feature:
- Macro: SEQ_TIMING_CHECK_EN.
- Defined: the one-hot and step comparison above is active, and ERR is a sticky register.
- Undefined: ERR is tied to 0 and the T input is unused. The sequencer runs purely from its shadow step count.

Test Plan:
- Reset, then START pulse with OPCODE=5'b00010 → LD_AR at T0, INC_PC at T1, LD_IR at T2, DECODE at T3, EXEC with EXEC_STEP=0 at T4. SC_CLR=1 during T4, counter shows T0 next cycle, FETCH restarts.
- OPCODE=5'b11000 (4 exec steps) → EXEC_STEP counts 0,1,2,3 over T4..T7. SC_CLR high only during T7. BUSY stays 1.
- STOP_REQ pulse during T1 with OPCODE=5'b01000 → instruction completes through T6, then IDLE with SC_CLR=1. No further LD_AR until the next START.
- OPCODE=HALT_OP (5'b11111) → after T7, HALTED=1 and SC_CLR=1. START is ignored. CLR returns to IDLE with HALTED=0.
- With SEQ_TIMING_CHECK_EN defined, force T=T5 while step=4 → ERR=1 next cycle, state HALT, ERR held through 10 further START pulses until CLR. With the macro undefined, the same stimulus gives ERR=0 and normal completion.
- Assert CLR for one cycle during EXE step 5 → SC_CLR=1 and BUSY=0 immediately. Outputs match reset values.
